fb_write_buffer: RTL and testbench

//  Sits between the processor memory-write port and the VRAM controller.

---
 rtl/fb_write_buffer_pkg.sv | 8 +
 rtl/fb_sync_fifo.sv | 51 +++++
 rtl/fb_write_buffer.sv | 90 +++++++++
 tb/tb_fb_write_buffer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fb_write_buffer_pkg.sv
// Default framebuffer geometry shared by the write buffer, VRAM controller and scanout.
package fb_write_buffer_pkg;
    localparam logic [31:0] FB_BASE_DEF  = 32'h0000_8000;
    localparam int unsigned FB_WORDS_DEF = 76800;
    localparam int          DATA_W_DEF   = 16;
    localparam int          VADDR_W_DEF  = 17;
    localparam int          DEPTH_DEF    = 8;
endpackage

// File: rtl/fb_sync_fifo.sv
// Synchronous FIFO with occupancy count; optional tail-overwrite port (FB_WRITE_COALESCE_EN).
module fb_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 33
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_wdata,
`ifdef FB_WRITE_COALESCE_EN
    input  logic                     i_tw_en,
    input  logic [W-1:0]             i_tw_data,
    output logic [W-1:0]             o_tail,
`endif
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [AW:0]   r_count;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
            if (i_push && !i_pop)      r_count <= r_count + 1'b1;
            else if (i_pop && !i_push) r_count <= r_count - 1'b1;
        end
    end

    // Storage needs no reset: nothing reads it while count is zero.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_wdata;
`ifdef FB_WRITE_COALESCE_EN
        else if (i_tw_en) r_mem[r_wr - 1'b1] <= i_tw_data;
`endif
    end

`ifdef FB_WRITE_COALESCE_EN
    assign o_tail  = r_mem[r_wr - 1'b1];
`endif
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;
endmodule

// File: rtl/fb_write_buffer.sv
// Framebuffer write buffer: window-filters processor writes, queues them, drains to VRAM.
// Optional FB_WRITE_COALESCE_EN merges a write into the tail entry when offsets match.
module fb_write_buffer
    import fb_write_buffer_pkg::*;
#(
    parameter int                DEPTH    = DEPTH_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = 32,
    parameter int                VADDR_W  = VADDR_W_DEF,
    parameter logic [ADDR_W-1:0] FB_BASE  = ADDR_W'(FB_BASE_DEF),
    parameter int unsigned       FB_WORDS = FB_WORDS_DEF
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               mem_write_enable,
    input  logic [ADDR_W-1:0]  mem_write_addr,
    input  logic [DATA_W-1:0]  mem_write_data,
    output logic               stall,
    output logic               vram_req,
    output logic [VADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0]  vram_data,
    input  logic               vram_ack,
    output logic               oob_pulse,
    output logic               overflow
);
    localparam int              CW      = $clog2(DEPTH);
    localparam int              W       = VADDR_W + DATA_W;
    localparam logic [CW:0]     L_FULL  = (CW+1)'(DEPTH);
    localparam logic [CW:0]     L_STALL = (CW+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] L_LIMIT = {1'b0, FB_BASE} + (ADDR_W+1)'(FB_WORDS);

    logic               w_hit, w_push, w_pop, w_full, w_req, w_coal;
    logic [VADDR_W-1:0] w_off;
    logic [W-1:0]       w_head;
    logic [CW:0]        w_count, w_next;
    logic               r_stall, r_oob, r_ovf;

    // One extra bit on the upper bound so a window ending at the top of the space cannot wrap.
    assign w_hit  = (mem_write_addr >= FB_BASE) && ({1'b0, mem_write_addr} < L_LIMIT);
    assign w_off  = VADDR_W'(mem_write_addr - FB_BASE);
    assign w_req  = (w_count != '0);
    assign w_pop  = w_req && vram_ack;
    assign w_full = (w_count == L_FULL);

`ifdef FB_WRITE_COALESCE_EN
    logic [W-1:0] w_tail;
    // Tail equals head when one entry is queued; if that entry leaves now, push instead.
    assign w_coal = mem_write_enable && w_hit && w_req && (w_tail[W-1:DATA_W] == w_off)
                    && !(w_pop && w_count == (CW+1)'(1));
`else
    assign w_coal = 1'b0;
`endif

    assign w_push = mem_write_enable && w_hit && !w_coal && (!w_full || w_pop);
    assign w_next = w_count + (CW+1)'(w_push) - (CW+1)'(w_pop);

    fb_sync_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_wdata   ({w_off, mem_write_data}),
`ifdef FB_WRITE_COALESCE_EN
        .i_tw_en   (w_coal),
        .i_tw_data ({w_off, mem_write_data}),
        .o_tail    (w_tail),
`endif
        .o_head    (w_head),
        .o_count   (w_count)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_stall <= 1'b0;
            r_oob   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_stall <= (w_next >= L_STALL);
            r_oob   <= mem_write_enable && !w_hit;
            r_ovf   <= r_ovf | (mem_write_enable && w_hit && !w_coal && w_full && !w_pop);
        end
    end

    assign stall     = r_stall;
    assign oob_pulse = r_oob;
    assign overflow  = r_ovf;
    assign vram_req  = w_req;
    assign vram_addr = w_req ? w_head[W-1:DATA_W] : '0;
    assign vram_data = w_req ? w_head[DATA_W-1:0] : '0;
endmodule

// File: tb/tb_fb_write_buffer.sv
// Directed bench for fb_write_buffer: vector table plus reset/backpressure/overflow/coalesce sequences.
module tb_fb_write_buffer;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] addr = '0;
    logic [15:0] data = '0;
    logic        ack = 1'b0;
    logic        stall, req, oob, ovf;
    logic [16:0] vaddr;
    logic [15:0] vdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fb_write_buffer dut (
        .clk              (clk),
        .clr              (clr),
        .mem_write_enable (we),
        .mem_write_addr   (addr),
        .mem_write_data   (data),
        .stall            (stall),
        .vram_req         (req),
        .vram_addr        (vaddr),
        .vram_data        (vdata),
        .vram_ack         (ack),
        .oob_pulse        (oob),
        .overflow         (ovf)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [15:0] data;
        logic        ack;
        logic        req;
        logic [16:0] vaddr;
        logic [15:0] vdata;
        logic        stall;
        logic        oob;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        we  = 1'b0;
        ack = 1'b0;
        clr = 1'b0;
        step();
        step();
        clr = 1'b1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [15:0] d);
        we   = 1'b1;
        addr = a;
        data = d;
        step();
        we   = 1'b0;
    endtask

    task automatic head(input string name, input logic [16:0] a, input logic [15:0] d);
        chk({name, "_req"},  32'(req), 32'd1);
        chk({name, "_addr"}, 32'(vaddr), 32'(a));
        chk({name, "_data"}, 32'(vdata), 32'(d));
    endtask

    initial begin
        // Passthrough and window edges with ack tied high
        vt[0] = '{1'b1, 32'h0000_8000, 16'hF800, 1'b1, 1'b1, 17'd0,      16'hF800, 1'b0, 1'b0};
        vt[1] = '{1'b1, 32'h0000_8005, 16'h1234, 1'b1, 1'b1, 17'd5,      16'h1234, 1'b0, 1'b0};
        vt[2] = '{1'b1, 32'h0000_7FFF, 16'hAAAA, 1'b1, 1'b0, 17'd0,      16'h0000, 1'b0, 1'b1};
        vt[3] = '{1'b1, 32'h0001_AC00, 16'hBBBB, 1'b1, 1'b0, 17'd0,      16'h0000, 1'b0, 1'b1};
        vt[4] = '{1'b1, 32'h0001_ABFF, 16'hCCCC, 1'b1, 1'b1, 17'h12BFF,  16'hCCCC, 1'b0, 1'b0};
        vt[5] = '{1'b0, 32'h0000_0000, 16'h0000, 1'b1, 1'b0, 17'd0,      16'h0000, 1'b0, 1'b0};
        vt[6] = '{1'b1, 32'hFFFF_FFFF, 16'h0001, 1'b1, 1'b0, 17'd0,      16'h0000, 1'b0, 1'b1};
        vt[7] = '{1'b0, 32'h0000_0000, 16'h0000, 1'b1, 1'b0, 17'd0,      16'h0000, 1'b0, 1'b0};

        // Reset state
        #2;
        chk("rst_req",   32'(req),   32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_oob",   32'(oob),   32'd0);
        chk("rst_ovf",   32'(ovf),   32'd0);
        chk("rst_addr",  32'(vaddr), 32'd0);
        chk("rst_data",  32'(vdata), 32'd0);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            we = vt[i].we; addr = vt[i].addr; data = vt[i].data; ack = vt[i].ack;
            step();
            chk($sformatf("vec%0d_req", i),   32'(req),   32'(vt[i].req));
            chk($sformatf("vec%0d_addr", i),  32'(vaddr), 32'(vt[i].vaddr));
            chk($sformatf("vec%0d_data", i),  32'(vdata), 32'(vt[i].vdata));
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vt[i].stall));
            chk($sformatf("vec%0d_oob", i),   32'(oob),   32'(vt[i].oob));
        end
        we = 1'b0;

        // Async reset with three entries queued
        do_reset();
        for (int i = 0; i < 3; i++) wr(32'h8000 + 32'(i), 16'h0A00 + 16'(i));
        chk("midrst_pre_req", 32'(req), 32'd1);
        #2 clr = 1'b0;
        #1;
        chk("midrst_req",   32'(req),   32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_ovf",   32'(ovf),   32'd0);
        chk("midrst_addr",  32'(vaddr), 32'd0);
        #2 clr = 1'b1;
        step();
        chk("postrst_req", 32'(req), 32'd0);
        wr(32'h8003, 16'h5555);
        head("postrst_fresh", 17'd3, 16'h5555);

        // Backpressure: eight writes, stall rises after the seventh
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr(32'h8000 + 32'(i), 16'h0100 + 16'(i));
            chk($sformatf("bp_stall%0d", i), 32'(stall), (i >= 6) ? 32'd1 : 32'd0);
        end
        chk("bp_ovf", 32'(ovf), 32'd0);
        ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            head($sformatf("bp_drain%0d", i), 17'(i), 16'h0100 + 16'(i));
            step();
        end
        chk("bp_empty_req", 32'(req),   32'd0);
        chk("bp_unstall",   32'(stall), 32'd0);

        // Overflow: nine writes ignoring stall, then push+pop at full
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wr(32'h8020 + 32'(i), 16'h0200 + 16'(i));
            if (i == 7) chk("ovf_at8", 32'(ovf), 32'd0);
        end
        chk("ovf_set", 32'(ovf), 32'd1);
        head("ovf_head0", 17'h20, 16'h0200);
        ack = 1'b1;
        wr(32'h8040, 16'h0300);
        chk("ovf_full_stall", 32'(stall), 32'd1);
        head("ovf_head1", 17'h21, 16'h0201);
        for (int i = 1; i < 8; i++) begin
            head($sformatf("ovf_drain%0d", i), 17'h20 + 17'(i), 16'h0200 + 16'(i));
            step();
        end
        head("ovf_last", 17'h40, 16'h0300);
        step();
        chk("ovf_empty_req", 32'(req), 32'd0);
        chk("ovf_sticky",    32'(ovf), 32'd1);

        // Repeated writes to one pixel
        do_reset();
        wr(32'h8010, 16'h0001);
        wr(32'h8010, 16'h0002);
`ifdef FB_WRITE_COALESCE_EN
        head("coal_one", 17'h10, 16'h0002);
        ack = 1'b1;
        step();
`else
        head("coal_first", 17'h10, 16'h0001);
        ack = 1'b1;
        step();
        head("coal_second", 17'h10, 16'h0002);
        step();
`endif
        chk("coal_empty_req", 32'(req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
